mvm_uart_host: RTL and testbench

MVM_UART_HOST -- requirements
Module: mvm_uart_host

---
 rtl/mvm_uart_host.sv | 238 +++++++++++++++++++++++
 tb/tb_mvm_uart_host.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_uart_host.sv
// Host end of the matrix-vector UART link: serialises one kx word, then collects one y word.
// Optional stop-bit checking with a sticky frame_err output: define MVM_UART_HOST_FRAME_ERR_EN.
module mvm_uart_host #(
  parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
  parameter int BITS_PER_WORD    = 8,
  parameter int R                = 8,
  parameter int C                = 8,
  parameter int W_X              = 8,
  parameter int W_K              = 8,
  parameter int W_Y_OUT          = 32,
  localparam int W_BUS_KX        = R * C * W_K + C * W_X,
  localparam int W_BUS_Y         = R * W_Y_OUT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s_axis_kx_tvalid,
  output logic                s_axis_kx_tready,
  input  logic [W_BUS_KX-1:0] s_axis_kx_tdata,
  output logic                m_axis_y_tvalid,
  input  logic                m_axis_y_tready,
  output logic [W_BUS_Y-1:0]  m_axis_y_tdata,
  output logic                tx,
  input  logic                rx
`ifdef MVM_UART_HOST_FRAME_ERR_EN
  ,
  output logic                frame_err
`endif
);

  localparam int N_TX  = W_BUS_KX / BITS_PER_WORD;
  localparam int N_RX  = W_BUS_Y / BITS_PER_WORD;
  localparam int CLK_W = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int BIT_W = $clog2(BITS_PER_WORD + 2);
  localparam int TXC_W = $clog2(N_TX + 1);
  localparam int RXC_W = $clog2(N_RX + 1);
  localparam int HALF  = (CLOCKS_PER_PULSE / 2 > 0) ? CLOCKS_PER_PULSE / 2 : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] RECV = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                kx_ready_q, kx_ready_d;
  logic [W_BUS_KX-1:0] kx_q, kx_d;
  logic                tx_q, tx_d;
  logic [CLK_W-1:0]    tx_clk_q, tx_clk_d;
  logic [BIT_W-1:0]    tx_bit_q, tx_bit_d;
  logic [TXC_W-1:0]    tx_chr_q, tx_chr_d;

  logic                rx_meta_q, rx_sync_q, rx_prev_q;
  logic                rx_busy_q, rx_busy_d;
  logic [CLK_W-1:0]    rx_clk_q, rx_clk_d;
  logic [BIT_W-1:0]    rx_bit_q, rx_bit_d;
  logic [BITS_PER_WORD-1:0] rx_sh_q, rx_sh_d;
  logic                rx_done, stop_ok, rx_store;

  logic [W_BUS_Y-1:0]  y_q, y_d;
  logic [RXC_W-1:0]    y_cnt_q, y_cnt_d;

  logic kx_hs, y_hs;

  assign s_axis_kx_tready = kx_ready_q;
  assign m_axis_y_tvalid  = (state_q == OUT);
  assign m_axis_y_tdata   = y_q;
  assign tx               = tx_q;

  assign kx_hs = s_axis_kx_tvalid & kx_ready_q;
  assign y_hs  = m_axis_y_tvalid & m_axis_y_tready;

`ifdef MVM_UART_HOST_FRAME_ERR_EN
  logic frame_err_q;
  assign stop_ok   = rx_sync_q;
  assign frame_err = frame_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err_q <= 1'b0;
    end else if (rx_done && !rx_sync_q) begin
      frame_err_q <= 1'b1;
    end
  end
`else
  assign stop_ok = 1'b1;
`endif

  assign rx_store = rx_done & stop_ok & (state_q == RECV);

  // Receiver runs in every state; only RECV keeps what it hears.
  always_comb begin
    rx_busy_d = rx_busy_q;
    rx_clk_d  = rx_clk_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_done   = 1'b0;
    if (!rx_busy_q) begin
      if (rx_prev_q && !rx_sync_q) begin
        rx_busy_d = 1'b1;
        rx_clk_d  = '0;
        rx_bit_d  = '0;
      end
    end else if (rx_bit_q == '0) begin
      if (rx_clk_q == CLK_W'(HALF - 1)) begin
        rx_clk_d = '0;
        if (rx_sync_q) begin
          rx_busy_d = 1'b0;
        end else begin
          rx_bit_d = BIT_W'(1);
        end
      end else begin
        rx_clk_d = rx_clk_q + CLK_W'(1);
      end
    end else if (rx_clk_q == CLK_W'(CLOCKS_PER_PULSE - 1)) begin
      rx_clk_d = '0;
      if (rx_bit_q == BIT_W'(BITS_PER_WORD + 1)) begin
        rx_busy_d = 1'b0;
        rx_done   = 1'b1;
      end else begin
        rx_sh_d  = {rx_sync_q, rx_sh_q[BITS_PER_WORD-1:1]};
        rx_bit_d = rx_bit_q + BIT_W'(1);
      end
    end else begin
      rx_clk_d = rx_clk_q + CLK_W'(1);
    end
  end

  // kx_q is consumed LSB-first one data bit at a time, so the next character is
  // always sitting at the bottom when its start bit ends.
  always_comb begin
    state_d  = state_q;
    kx_d     = kx_q;
    tx_d     = tx_q;
    tx_clk_d = tx_clk_q;
    tx_bit_d = tx_bit_q;
    tx_chr_d = tx_chr_q;
    y_d      = y_q;
    y_cnt_d  = y_cnt_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (kx_hs) begin
          state_d  = SEND;
          kx_d     = s_axis_kx_tdata;
          tx_d     = 1'b0;
          tx_clk_d = '0;
          tx_bit_d = '0;
          tx_chr_d = '0;
        end
      end
      SEND: begin
        if (tx_clk_q == CLK_W'(CLOCKS_PER_PULSE - 1)) begin
          tx_clk_d = '0;
          if (tx_bit_q == BIT_W'(BITS_PER_WORD + 1)) begin
            tx_bit_d = '0;
            if (tx_chr_q == TXC_W'(N_TX - 1)) begin
              state_d = RECV;
              tx_d    = 1'b1;
            end else begin
              tx_chr_d = tx_chr_q + TXC_W'(1);
              tx_d     = 1'b0;
            end
          end else if (tx_bit_q == BIT_W'(BITS_PER_WORD)) begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
            tx_d     = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
            tx_d     = kx_q[0];
            kx_d     = kx_q >> 1;
          end
        end else begin
          tx_clk_d = tx_clk_q + CLK_W'(1);
        end
      end
      RECV: begin
        tx_d = 1'b1;
        if (rx_store) begin
          y_d = {rx_sh_q, y_q[W_BUS_Y-1:BITS_PER_WORD]};
          if (y_cnt_q == RXC_W'(N_RX - 1)) begin
            y_cnt_d = '0;
            state_d = OUT;
          end else begin
            y_cnt_d = y_cnt_q + RXC_W'(1);
          end
        end
      end
      OUT: begin
        tx_d = 1'b1;
        if (y_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    kx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      kx_ready_q <= 1'b0;
      kx_q       <= '0;
      tx_q       <= 1'b1;
      tx_clk_q   <= '0;
      tx_bit_q   <= '0;
      tx_chr_q   <= '0;
      rx_meta_q  <= 1'b0;
      rx_sync_q  <= 1'b0;
      rx_prev_q  <= 1'b0;
      rx_busy_q  <= 1'b0;
      rx_clk_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      y_q        <= '0;
      y_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      kx_ready_q <= kx_ready_d;
      kx_q       <= kx_d;
      tx_q       <= tx_d;
      tx_clk_q   <= tx_clk_d;
      tx_bit_q   <= tx_bit_d;
      tx_chr_q   <= tx_chr_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_busy_q  <= rx_busy_d;
      rx_clk_q   <= rx_clk_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      y_q        <= y_d;
      y_cnt_q    <= y_cnt_d;
    end
  end

endmodule

// File: tb/tb_mvm_uart_host.sv
// Directed bench for mvm_uart_host with CLOCKS_PER_PULSE=4, R=C=2 (N_TX=6, N_RX=8).
// Frame-error cases run only when MVM_UART_HOST_FRAME_ERR_EN is defined.
module tb_mvm_uart_host;
  localparam int CPP  = 4;
  localparam int W_KX = 48;
  localparam int W_Y  = 64;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            s_axis_kx_tvalid = 1'b0;
  logic            s_axis_kx_tready;
  logic [W_KX-1:0] s_axis_kx_tdata = '0;
  logic            m_axis_y_tvalid;
  logic            m_axis_y_tready = 1'b0;
  logic [W_Y-1:0]  m_axis_y_tdata;
  logic            tx;
  logic            rx = 1'b1;
`ifdef MVM_UART_HOST_FRAME_ERR_EN
  logic            frame_err;
`endif

  int n_err = 0;
  int n_chk = 0;

  mvm_uart_host #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (8),
    .R               (2),
    .C               (2),
    .W_X             (8),
    .W_K             (8),
    .W_Y_OUT         (32)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .s_axis_kx_tvalid(s_axis_kx_tvalid),
    .s_axis_kx_tready(s_axis_kx_tready),
    .s_axis_kx_tdata (s_axis_kx_tdata),
    .m_axis_y_tvalid (m_axis_y_tvalid),
    .m_axis_y_tready (m_axis_y_tready),
    .m_axis_y_tdata  (m_axis_y_tdata),
    .tx              (tx),
    .rx              (rx)
`ifdef MVM_UART_HOST_FRAME_ERR_EN
    ,
    .frame_err       (frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hands kx over and checks every tx cycle of the six characters.
  task automatic send_kx(input logic [W_KX-1:0] kx);
    int   waited = 0;
    logic rdy_seen = 1'b0;
    while (!s_axis_kx_tready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("kx_ready_idle", s_axis_kx_tready, 1);
    s_axis_kx_tvalid = 1'b1;
    s_axis_kx_tdata  = kx;
    @(negedge clk);
    s_axis_kx_tvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [39:0] obs;
      logic [39:0] exp;
      logic [7:0]  b;
      b = kx[8*i +: 8];
      for (int c = 0; c < 40; c++) begin
        if (!(i == 0 && c == 0)) @(negedge clk);
        obs[c] = tx;
        if (c < 4) exp[c] = 1'b0;
        else if (c >= 36) exp[c] = 1'b1;
        else exp[c] = b[c/4 - 1];
        if (s_axis_kx_tready) rdy_seen = 1'b1;
      end
      check("tx_char", {24'd0, obs}, {24'd0, exp});
    end
    @(negedge clk);
    check("tx_idle_after_send", tx, 1);
    check("kx_ready_low_busy", rdy_seen | s_axis_kx_tready, 0);
  endtask

  task automatic rx_byte(input logic [7:0] b, input int nstop, input bit bad_stop);
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPP) @(negedge clk);
    end
    if (bad_stop) begin
      rx = 1'b0;
      repeat (CPP) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPP * nstop) @(negedge clk);
  endtask

  task automatic wait_y();
    int k = 0;
    while (!m_axis_y_tvalid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("y_valid_timeout", m_axis_y_tvalid, 1);
  endtask

  initial begin
    logic [63:0] exp_y;
    logic [63:0] got_y;
    logic        got_v, after_v, after_rdy;
    bit          stable;

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_kx_ready", s_axis_kx_tready, 0);
    check("rst_y_valid", m_axis_y_tvalid, 0);
    check("rst_y_data", m_axis_y_tdata, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("kx_ready_after_rst", s_axis_kx_tready, 1);

    // Transaction 1: serialise, false start, then eight bytes with four stop bits.
    send_kx(48'h0605_0403_0201);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rx_byte(8'(8'h11 + j), 4, 1'b0);
      if (j == 6) check("y_not_early", m_axis_y_tvalid, 0);
    end
    wait_y();
    exp_y = 64'h1817_1615_1413_1211;
    check("y_data", m_axis_y_tdata, exp_y);

    stable = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!m_axis_y_tvalid || m_axis_y_tdata !== exp_y) stable = 1'b0;
    end
    check("y_hold", {63'd0, stable}, 1);
    check("kx_ready_in_out", s_axis_kx_tready, 0);
    m_axis_y_tready = 1'b1;
    @(negedge clk);
    m_axis_y_tready = 1'b0;
    check("y_valid_after_hs", m_axis_y_tvalid, 0);
    check("kx_ready_after_hs", s_axis_kx_tready, 1);

    // Reset in the start bit of the second character.
    s_axis_kx_tvalid = 1'b1;
    s_axis_kx_tdata  = 48'hdead_beef_cafe;
    @(negedge clk);
    s_axis_kx_tvalid = 1'b0;
    repeat (41) @(negedge clk);
    check("tx_start_chr1", tx, 0);
    rstn = 1'b0;
    #1;
    check("tx_on_reset", tx, 1);
    check("kx_ready_on_reset", s_axis_kx_tready, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("kx_ready_after_mid_rst", s_axis_kx_tready, 1);
    check("tx_after_mid_rst", tx, 1);
    check("y_valid_after_mid_rst", m_axis_y_tvalid, 0);

    // Transaction 3: y_tready already high, so tvalid lasts one cycle.
    m_axis_y_tready = 1'b1;
    send_kx(48'hc3a5_5a3c_f00f);
    exp_y = '0;
    for (int j = 0; j < 8; j++) exp_y[8*j +: 8] = 8'(8'ha5 + j * 29);
    got_y = '0;
    got_v = 1'b0;
    after_v = 1'b1;
    after_rdy = 1'b0;
    fork
      begin
        for (int j = 0; j < 8; j++) rx_byte(8'(8'ha5 + j * 29), 2, 1'b0);
      end
      begin
        int k = 0;
        while (!m_axis_y_tvalid && k < 1000) begin
          @(negedge clk);
          k++;
        end
        got_v = m_axis_y_tvalid;
        got_y = m_axis_y_tdata;
        @(negedge clk);
        after_v   = m_axis_y_tvalid;
        after_rdy = s_axis_kx_tready;
      end
    join
    check("y3_valid", got_v, 1);
    check("y3_data", got_y, exp_y);
    check("y3_valid_one_cycle", after_v, 0);
    check("y3_kx_ready", after_rdy, 1);
    m_axis_y_tready = 1'b0;

`ifdef MVM_UART_HOST_FRAME_ERR_EN
    // Transaction 4: a bad-stop byte is dropped, eight good bytes follow.
    check("frame_err_clear", frame_err, 0);
    send_kx(48'h0123_4567_89ab);
    rx_byte(8'hee, 2, 1'b1);
    check("frame_err_set", frame_err, 1);
    for (int j = 0; j < 8; j++) rx_byte(8'(8'h31 + j), 2, 1'b0);
    wait_y();
    check("y4_data", m_axis_y_tdata, 64'h3837_3635_3433_3231);
    m_axis_y_tready = 1'b1;
    @(negedge clk);
    m_axis_y_tready = 1'b0;
    check("y4_valid_after_hs", m_axis_y_tvalid, 0);
    check("frame_err_sticky", frame_err, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
